// File: rtl/ysyx_2022040010_uncache_pkg.sv
// rtl/ysyx_2022040010_uncache_pkg.sv - shared encodings for the uncached load/store controller
package ysyx_2022040010_uncache_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUS_REQ  = 2'd1,
        ST_BUS_RESP = 2'd2,
        ST_CPU_RESP = 2'd3
    } state_e;

    function automatic int lane_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    localparam int LANE_W = lane_bits(64);

endpackage

// File: rtl/ysyx_2022040010_uncache_ctrl_if.sv
// rtl/ysyx_2022040010_uncache_ctrl_if.sv - LSU-side and bus-side handshake bundle
interface ysyx_2022040010_uncache_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              bus_req_valid;
    logic              bus_req_ready;
    logic              bus_req_wr;
    logic [ADDR_W-1:0] bus_req_addr;
    logic [1:0]        bus_req_size;
    logic [DATA_W-1:0] bus_req_wdata;
    logic [STRB_W-1:0] bus_req_wstrb;
    logic              bus_resp_valid;
    logic              bus_resp_ready;
    logic [DATA_W-1:0] bus_resp_rdata;
    logic              bus_resp_err;
    logic              wr_err_sticky;

    modport slave (
        input  req_valid, req_wr, req_addr, req_size, req_signed, req_wdata,
               bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err,
        output req_ready, resp_valid, resp_rdata, resp_err,
               bus_req_valid, bus_req_wr, bus_req_addr, bus_req_size,
               bus_req_wdata, bus_req_wstrb, bus_resp_ready, wr_err_sticky
    );

    modport master (
        output req_valid, req_wr, req_addr, req_size, req_signed, req_wdata,
               bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               bus_req_valid, bus_req_wr, bus_req_addr, bus_req_size,
               bus_req_wdata, bus_req_wstrb, bus_resp_ready, wr_err_sticky
    );

endinterface

// File: rtl/ysyx_2022040010_uncache_lane.sv
// rtl/ysyx_2022040010_uncache_lane.sv - byte-lane store shift/strobe and load extract/extend
module ysyx_2022040010_uncache_lane
    import ysyx_2022040010_uncache_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [lane_bits(DATA_W)-1:0] lane,
    input  logic [1:0]                   size,
    input  logic                         sign,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W-1:0]            rdata,
    output logic [DATA_W-1:0]            wdata_sh,
    output logic [DATA_W/8-1:0]          wstrb,
    output logic [DATA_W-1:0]            rdata_ext
);
    localparam int STRB_W = DATA_W / 8;

    logic [STRB_W-1:0] mask_b;
    logic [DATA_W-1:0] sh;
    int                nbits;
    logic              msb;

    always_comb begin
        mask_b = '0;
        case (size)
            SZ_B:    mask_b = STRB_W'(1);
            SZ_H:    mask_b = STRB_W'(3);
            SZ_W:    mask_b = STRB_W'(15);
            default: mask_b = '1;
        endcase
    end

    assign wstrb    = mask_b << lane;
    assign wdata_sh = wdata << {lane, 3'b000};
    assign sh       = rdata >> {lane, 3'b000};

    // Bits above the access width take the fill bit: the sign for signed loads, else 0.
    always_comb begin
        nbits     = DATA_W;
        msb       = 1'b0;
        rdata_ext = '0;
        case (size)
            SZ_B:    begin nbits = 8;  msb = sh[7];  end
            SZ_H:    begin nbits = 16; msb = sh[15]; end
            SZ_W:    begin nbits = 32; msb = sh[31]; end
            default: begin nbits = DATA_W; msb = 1'b0; end
        endcase
        for (int i = 0; i < DATA_W; i++) begin
            rdata_ext[i] = (i < nbits) ? sh[i] : (sign & msb);
        end
    end

endmodule

// File: rtl/ysyx_2022040010_uncache_ctrl.sv
// rtl/ysyx_2022040010_uncache_ctrl.sv - single-outstanding uncached load/store controller
// YSYX_2022040010_UNCACHE_POSTED_WR_EN: stores respond early and bus errors set wr_err_sticky
module ysyx_2022040010_uncache_ctrl
    import ysyx_2022040010_uncache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input logic                          clk,
    input logic                          rst,
    ysyx_2022040010_uncache_ctrl_if.slave io
);
    localparam int LW = lane_bits(DATA_W);

    state_e            state, state_nx;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_signed;
    logic              r_wr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              started;
    logic              idle_rdy;
    logic              accept;
    logic              misalign;
    logic              illegal;
    logic              posted_wr;
    logic              post_pulse;
    logic              sticky;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_rdata;
    logic [STRB_W-1:0] lane_wstrb;

    assign idle_rdy = started && (state == ST_IDLE);
    assign accept   = io.req_valid && idle_rdy;

    always_comb begin
        misalign = 1'b0;
        case (io.req_size)
            SZ_H:    misalign = io.req_addr[0];
            SZ_W:    misalign = |io.req_addr[1:0];
            SZ_D:    misalign = |io.req_addr[2:0];
            default: misalign = 1'b0;
        endcase
    end

    assign illegal = misalign || ((io.req_size == SZ_D) && (DATA_W == 32));

    ysyx_2022040010_uncache_lane #(.DATA_W(DATA_W)) u_lane (
        .lane      (r_addr[LW-1:0]),
        .size      (r_size),
        .sign      (r_signed),
        .wdata     (r_wdata),
        .rdata     (io.bus_resp_rdata),
        .wdata_sh  (lane_wdata),
        .wstrb     (lane_wstrb),
        .rdata_ext (lane_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx          = state;
        io.req_ready      = idle_rdy;
        io.bus_req_valid  = 1'b0;
        io.bus_resp_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_nx = illegal ? ST_CPU_RESP : ST_BUS_REQ;
            end
            ST_BUS_REQ: begin
                io.bus_req_valid = 1'b1;
                if (io.bus_req_ready) state_nx = ST_BUS_RESP;
            end
            ST_BUS_RESP: begin
                io.bus_resp_ready = 1'b1;
                // Posted stores already answered the LSU, so skip the response cycle.
                if (io.bus_resp_valid) state_nx = posted_wr ? ST_IDLE : ST_CPU_RESP;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started  <= 1'b0;
            r_addr   <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_wr     <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            started <= 1'b1;
            if (accept) begin
                r_addr   <= io.req_addr;
                r_size   <= io.req_size;
                r_signed <= io.req_signed;
                r_wr     <= io.req_wr;
                r_wdata  <= io.req_wdata;
                r_rdata  <= '0;
                r_err    <= illegal;
            end
            if ((state == ST_BUS_RESP) && io.bus_resp_valid) begin
                r_err   <= io.bus_resp_err;
                r_rdata <= (io.bus_resp_err || r_wr) ? '0 : lane_rdata;
            end
        end
    end

`ifdef YSYX_2022040010_UNCACHE_POSTED_WR_EN
    assign posted_wr = r_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            post_pulse <= 1'b0;
            sticky     <= 1'b0;
        end else begin
            post_pulse <= accept && io.req_wr && !illegal;
            if ((state == ST_BUS_RESP) && io.bus_resp_valid && r_wr && io.bus_resp_err)
                sticky <= 1'b1;
        end
    end
`else
    assign posted_wr  = 1'b0;
    assign post_pulse = 1'b0;
    assign sticky     = 1'b0;
`endif

    assign io.resp_valid    = (state == ST_CPU_RESP) || post_pulse;
    assign io.resp_err      = (state == ST_CPU_RESP) && r_err;
    assign io.resp_rdata    = (state == ST_CPU_RESP) ? r_rdata : '0;
    assign io.bus_req_wr    = io.bus_req_valid && r_wr;
    assign io.bus_req_addr  = io.bus_req_valid ? r_addr : '0;
    assign io.bus_req_size  = io.bus_req_valid ? r_size : '0;
    assign io.bus_req_wdata = io.bus_req_wr ? lane_wdata : '0;
    assign io.bus_req_wstrb = io.bus_req_wr ? lane_wstrb : '0;
    assign io.wr_err_sticky = sticky;

endmodule

// File: tb/tb_ysyx_2022040010_uncache_ctrl.sv
// tb/tb_ysyx_2022040010_uncache_ctrl.sv - directed bench; also covers YSYX_2022040010_UNCACHE_POSTED_WR_EN
module tb_ysyx_2022040010_uncache_ctrl;

`ifdef YSYX_2022040010_UNCACHE_POSTED_WR_EN
    localparam logic POSTED = 1'b1;
`else
    localparam logic POSTED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ysyx_2022040010_uncache_ctrl_if #(.ADDR_W(32), .DATA_W(64)) io ();

    ysyx_2022040010_uncache_ctrl #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Presents a request for one edge; returns in the cycle after the accept edge.
    task automatic req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [63:0] wd);
        io.req_valid  = 1'b1;
        io.req_wr     = wr;
        io.req_addr   = addr;
        io.req_size   = size;
        io.req_signed = sgn;
        io.req_wdata  = wd;
        @(negedge clk);
        io.req_valid  = 1'b0;
    endtask

    task automatic bus(input logic rdy, input logic rv, input logic [63:0] rd, input logic er);
        io.bus_req_ready  = rdy;
        io.bus_resp_valid = rv;
        io.bus_resp_rdata = rd;
        io.bus_resp_err   = er;
    endtask

    initial begin
        rst = 1'b0;
        io.req_valid = 1'b0; io.req_wr = 1'b0; io.req_addr = '0; io.req_size = '0;
        io.req_signed = 1'b0; io.req_wdata = '0;
        bus(1'b0, 1'b0, 64'h0, 1'b0);
        cyc(); cyc();
        chk("rst_req_ready", io.req_ready, 0);
        chk("rst_outs", {io.bus_req_valid, io.resp_valid, io.bus_resp_ready, io.wr_err_sticky}, 0);
        chk("rst_bus_fields", {io.bus_req_addr, io.bus_req_wstrb, io.bus_req_wr}, 0);
        rst = 1'b1;
        cyc();
        chk("rel_req_ready", io.req_ready, 1);

        // LB signed at lane 3, zero-wait bus
        bus(1'b1, 1'b1, 64'h0000_0000_8000_0000, 1'b0);
        req(1'b0, 32'h0000_1003, 2'd0, 1'b1, 64'h0);
        chk("lb_c1_bus", {io.bus_req_valid, io.bus_req_wr, io.bus_req_wstrb}, {1'b1, 1'b0, 8'h00});
        chk("lb_c1_addr", io.bus_req_addr, 32'h0000_1003);
        chk("lb_c1_ready", io.req_ready, 0);
        cyc();
        chk("lb_c2", {io.bus_resp_ready, io.resp_valid}, 2'b10);
        cyc();
        chk("lb_c3_valid", {io.resp_valid, io.resp_err}, 2'b10);
        chk("lb_c3_rdata", io.resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        cyc();
        chk("lb_c4", {io.resp_valid, io.req_ready}, 2'b01);

        // SH at lane 6; store response carries no data
        bus(1'b1, 1'b1, 64'h1122_3344_5566_7788, 1'b0);
        req(1'b1, 32'h0000_1006, 2'd1, 1'b0, 64'h0000_0000_0000_BEEF);
        chk("sh_wstrb", io.bus_req_wstrb, 8'hC0);
        chk("sh_wdata", io.bus_req_wdata, 64'hBEEF_0000_0000_0000);
        chk("sh_c1", {io.bus_req_valid, io.bus_req_wr, io.bus_req_size, io.resp_valid},
            {1'b1, 1'b1, 2'd1, POSTED});
        cyc(); cyc();
        chk("sh_c3", {io.resp_valid, io.resp_err, io.req_ready}, {!POSTED, 1'b0, POSTED});
        chk("sh_c3_rdata", io.resp_rdata, 0);
        if (!POSTED) cyc();

        // LW misaligned: immediate error, no bus access
        req(1'b0, 32'h0000_1002, 2'd2, 1'b0, 64'h0);
        chk("lw_mis_c1", {io.resp_valid, io.resp_err, io.bus_req_valid}, 3'b110);
        chk("lw_mis_rdata", io.resp_rdata, 0);
        cyc();
        chk("lw_mis_c2", {io.resp_valid, io.req_ready, io.bus_req_valid}, 3'b010);

        // LD with 5 stalled cycles then bus error
        bus(1'b0, 1'b0, 64'h0, 1'b0);
        req(1'b0, 32'h0000_1008, 2'd3, 1'b0, 64'h0);
        for (int i = 0; i < 5; i++) begin
            chk("ld_stall_fields", {io.bus_req_valid, io.bus_req_addr, io.bus_req_size, io.resp_valid},
                {1'b1, 32'h0000_1008, 2'd3, 1'b0});
            if (i < 4) cyc();
        end
        bus(1'b1, 1'b0, 64'h0, 1'b0);
        cyc();
        chk("ld_c6", {io.bus_req_valid, io.bus_resp_ready}, 2'b01);
        bus(1'b0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
        cyc();
        chk("ld_err", {io.resp_valid, io.resp_err}, 2'b11);
        chk("ld_err_rdata", io.resp_rdata, 0);
        bus(1'b0, 1'b0, 64'h0, 1'b0);
        cyc();

        // Reset while waiting in BUS_RESP
        bus(1'b1, 1'b0, 64'h0, 1'b0);
        req(1'b0, 32'h0000_1001, 2'd0, 1'b0, 64'h0);
        cyc();
        chk("mid_bus_resp_ready", io.bus_resp_ready, 1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_outs", {io.bus_resp_ready, io.bus_req_valid, io.req_ready, io.resp_valid, io.resp_err},
            0);
        chk("mid_rst_addr", io.bus_req_addr, 0);
        cyc();
        rst = 1'b1;
        cyc();
        chk("mid_rel_ready", io.req_ready, 1);
        bus(1'b1, 1'b1, 64'h0000_9A00_0000_0000, 1'b0);
        req(1'b0, 32'h0000_1005, 2'd0, 1'b0, 64'h0);
        cyc(); cyc();
        chk("lbu_valid", {io.resp_valid, io.resp_err}, 2'b10);
        chk("lbu_rdata", io.resp_rdata, 64'h0000_0000_0000_009A);
        cyc();

        // SD followed by a bus error: posted vs non-posted completion
        bus(1'b1, 1'b0, 64'h0, 1'b0);
        req(1'b1, 32'h0000_1010, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF);
        chk("sd_c1", {io.resp_valid, io.resp_err, io.req_ready, io.bus_req_wstrb}, {POSTED, 1'b0, 1'b0, 8'hFF});
        chk("sd_wdata", io.bus_req_wdata, 64'h0123_4567_89AB_CDEF);
        cyc();
        chk("sd_c2", {io.resp_valid, io.req_ready, io.wr_err_sticky, io.bus_resp_ready}, 4'b0001);
        bus(1'b0, 1'b1, 64'h0, 1'b1);
        cyc();
        chk("sd_c3", {io.resp_valid, io.resp_err, io.req_ready}, {!POSTED, !POSTED, POSTED});
        chk("sd_sticky", io.wr_err_sticky, POSTED);
        bus(1'b0, 1'b0, 64'h0, 1'b0);
        cyc(); cyc();
        chk("sd_sticky_hold", {io.wr_err_sticky, io.req_ready}, {POSTED, 1'b1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_2022040010_uncache_ctrl.md
Name: ysyx_2022040010_uncache_ctrl

Overview:
Single-outstanding uncached load/store controller between the LSU and the device/memory bus; replaces the fixed 64-bit uncache data register.
- Parametrised bus width.
- Request/response handshakes on both sides.
- Address-misalignment error detection.
- Byte-lane alignment, write-strobe generation, and sign/zero extension of read data.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 64, bus/CPU data width; legal values 32 or 64.
- STRB_W, DATA_W/8, write-strobe width (derived; do not override).

Ports:
- clk  in  1  core clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  LSU uncached request.
- req_ready  out  1  controller idle, can accept.
- req_wr  in  1  1=store, 0=load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  0=B, 1=H, 2=W, 3=D.
- req_signed  in  1  sign-extend load result.
- req_wdata  in  DATA_W  store data, LSB-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  extended load data (0 for stores).
- resp_err  out  1  misaligned request, illegal size, or bus error.
- bus_req_valid  out  1  bus request.
- bus_req_ready  in  1  bus accepts.
- bus_req_wr  out  1  write.
- bus_req_addr  out  ADDR_W  request address, passed through unmodified.
- bus_req_size  out  2  size.
- bus_req_wdata  out  DATA_W  lane-shifted store data.
- bus_req_wstrb  out  STRB_W  byte strobes.
- bus_resp_valid  in  1  bus response.
- bus_resp_ready  out  1  controller accepts response.
- bus_resp_rdata  in  DATA_W  raw bus read data.
- bus_resp_err  in  1  bus error.
- wr_err_sticky  out  1  posted-write error flag.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0 except req_ready, which is 1 after reset deasserts. Internal request registers cleared.
- Reset mid-operation: bus_req_valid drops immediately. Any in-flight response is ignored; the bus side must tolerate this.
- FSM states: IDLE, BUS_REQ, BUS_RESP, CPU_RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register addr/size/signed/wr/wdata.
  - Legal request → BUS_REQ.
  - Misaligned (addr not multiple of 2^size) or size=3 with DATA_W=32 → CPU_RESP with error set; no bus access.
- BUS_REQ:
  - bus_req_valid=1.
  - All bus_req_* fields held stable until bus_req_ready.
  - On handshake → BUS_RESP.
- BUS_RESP:
  - bus_resp_ready=1.
  - On bus_resp_valid, capture extracted data and bus_resp_err → CPU_RESP.
- CPU_RESP:
  - resp_valid=1 for exactly one cycle, no backpressure.
  - resp_rdata/resp_err valid in the same cycle.
  - Next state IDLE.
- Latency: with zero-wait bus, resp_valid asserts 3 cycles after the accept edge. Misaligned requests: 1 cycle.
- Lane math: lane = addr[log2(STRB_W)-1:0].
  - wstrb = ((1<<(1<<size))-1) << lane.
  - bus_req_wdata = req_wdata << (8*lane).
  - Read data = (rdata >> 8*lane), masked to 8·2^size bits, then sign-extended if req_signed, else zero-extended.
  - size=3: full word, no extension.
- resp_rdata is 0 for stores and for erroneous responses.
- A req_valid arriving while not IDLE is not accepted (req_ready=0). The LSU holds the request.

Optional Feature:
- Macro: YSYX_2022040010_UNCACHE_POSTED_WR_EN.
- Enabled:
  - Stores complete early: resp_valid pulses 1 cycle after accept, with resp_err=0 (misaligned stores still report err and skip the bus).
  - The FSM continues BUS_REQ/BUS_RESP silently; req_ready stays 0 until the bus response is consumed.
  - bus_resp_err on a posted write sets wr_err_sticky, which is cleared only by reset.
- Disabled: stores complete through CPU_RESP like loads; wr_err_sticky tied 0.

Decomposition:
- Package ysyx_2022040010_uncache_pkg:
  - Size encodings (SZ_B/H/W/D).
  - FSM state encoding.
  - Helper constant LANE_W = log2(STRB_W).
- One sub-module, ysyx_2022040010_uncache_lane: combinational store lane shift/strobe generation plus load extract/extend, parametrised by DATA_W.

Test Plan:
- LB signed, addr 0x...03, bus_rdata 0x0000_0000_8000_0000 (byte3=0x80), zero-wait → resp_rdata=0xFFFF_FFFF_FFFF_FF80 at accept+3, err=0.
- SH addr 0x...06, wdata 0xBEEF → bus_req_wstrb=0xC0, bus_req_wdata=0xBEEF_0000_0000_0000; resp_valid after bus_resp.
- LW addr 0x...02 (misaligned) → no bus_req_valid, resp_valid+resp_err at accept+1, rdata=0.
- LD with bus_req_ready low 5 cycles then bus_resp_err=1 → fields stable throughout, resp_err=1, rdata=0.
- rst low during BUS_RESP → all outputs 0 immediately; after release req_ready=1 and a new LBU returns correct zero-extended data.
- POSTED_WR_EN: SD then bus_resp_err=1 → resp_valid at accept+1 with err=0; wr_err_sticky=1 after bus response; req_ready=0 until then.
